// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM states, default width and counter sizing for serial arithmetic cells
package serial_arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done job handshake with operands and result
interface serial_subtractor_if import serial_arith_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic start, busy, done, borrow;
  logic [WIDTH-1:0] a, b, diff;
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit full subtractor cell built from two half-subtractor stages
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);
  logic d1, bout1, bout2;
  assign d1 = A ^ B;
  assign bout1 = ~A & B;
  assign D = d1 ^ Bin;
  assign bout2 = ~d1 & Bin;
  assign Bout = bout1 | bout2;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock with start/busy/done handshake
module serial_subtractor import serial_arith_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  sub_state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, sr, diff_q;
  logic [CW-1:0] cnt;
  logic bq, borrow_q, d, bout, accept, last;
  full_subtractor fs (.A(sa[0]), .B(sb[0]), .Bin(bq), .D(d), .Bout(bout));
  assign accept = state != RUN && bus.start;
  assign last = state == RUN && cnt == CW'(WIDTH - 1);
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.diff = diff_q;
  assign bus.borrow = borrow_q;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = accept ? RUN : last ? DONE : state == RUN ? RUN : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      sr <= '0;
      bq <= 1'b0;
      cnt <= '0;
      diff_q <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      sa <= bus.a;
      sb <= bus.b;
      bq <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      sr <= {d, sr[WIDTH-1:1]};
      bq <= bout;
      cnt <= cnt + CW'(1);
      // the final bit goes straight to the outputs so partial results never show
      if (last) begin
        diff_q <= {d, sr[WIDTH-1:1]};
        borrow_q <= bout;
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of 8- and 16-bit serial subtractors against arithmetic reference
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(8)) i8 ();
  serial_subtractor_if #(.WIDTH(16)) i16 ();
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_diff(input int a, input int b, input int w);
    return 32'((a - b) & ((1 << w) - 1));
  endfunction

  task automatic job8(input string tag, input logic [7:0] a, input logic [7:0] b, input bit poke);
    int bc;
    bit got;
    logic [7:0] prev;
    prev = i8.diff;
    bc = 0;
    got = 0;
    i8.start = 1'b1;
    i8.a = a;
    i8.b = b;
    tick;
    i8.start = 1'b0;
    for (int i = 0; i < 14 && !got; i++) begin
      if (i8.done) got = 1;
      else begin
        if (i8.busy) bc++;
        if (i == 4) check({tag, "_hold"}, 32'(i8.diff), 32'(prev));
        if (poke && i == 1) begin
          i8.start = 1'b1;
          i8.a = 8'hFF;
          i8.b = 8'hFF;
        end else i8.start = 1'b0;
        tick;
      end
    end
    i8.start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
    check({tag, "_busy_at_done"}, 32'(i8.busy), 32'd0);
    check({tag, "_diff"}, 32'(i8.diff), ref_diff(int'(a), int'(b), 8));
    check({tag, "_borrow"}, 32'(i8.borrow), 32'(a < b));
    tick;
    check({tag, "_done_pulse"}, 32'(i8.done), 32'd0);
  endtask

  initial begin
    logic [7:0] pa [3] = '{8'h80, 8'h01, 8'h33};
    logic [7:0] pb [3] = '{8'h01, 8'h80, 8'h33};
    i8.start = 1'b0; i8.a = '0; i8.b = '0;
    i16.start = 1'b0; i16.a = '0; i16.b = '0;
    tick;
    tick;
    check("rst_busy", 32'(i8.busy), 32'd0);
    check("rst_done", 32'(i8.done), 32'd0);
    check("rst_diff", 32'(i8.diff), 32'd0);
    check("rst_borrow", 32'(i8.borrow), 32'd0);
    check("rst_diff16", 32'(i16.diff), 32'd0);
    rst_n = 1'b1;
    tick;
    job8("j5a3c", 8'h5A, 8'h3C, 0);
    job8("j0001", 8'h00, 8'h01, 0);
    job8("ja5a5", 8'hA5, 8'hA5, 0);
    job8("jff00", 8'hFF, 8'h00, 0);
    job8("jpoke", 8'h10, 8'h01, 1);
    i8.start = 1'b1; i8.a = 8'h77; i8.b = 8'h11;
    tick;
    i8.start = 1'b0;
    tick; tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(i8.busy), 32'd0);
    check("mid_rst_done", 32'(i8.done), 32'd0);
    check("mid_rst_diff", 32'(i8.diff), 32'd0);
    check("mid_rst_borrow", 32'(i8.borrow), 32'd0);
    tick;
    check("mid_rst_idle", 32'(i8.done | i8.busy), 32'd0);
    job8("j0903", 8'h09, 8'h03, 0);
    i8.start = 1'b1; i8.a = pa[0]; i8.b = pb[0];
    tick;
    for (int p = 0; p < 3; p++) begin
      for (int i = 1; i <= 8; i++) begin
        if (i < 8) tick;
        else begin
          tick;
          check($sformatf("b2b%0d_done", p), 32'(i8.done), 32'd1);
          check($sformatf("b2b%0d_busy", p), 32'(i8.busy), 32'd0);
          check($sformatf("b2b%0d_diff", p), 32'(i8.diff), ref_diff(int'(pa[p]), int'(pb[p]), 8));
          check($sformatf("b2b%0d_borrow", p), 32'(i8.borrow), 32'(pa[p] < pb[p]));
        end
        if (i < 8) check($sformatf("b2b%0d_run%0d", p, i), 32'({i8.busy, i8.done}), 32'b10);
      end
      if (p < 2) begin
        i8.a = pa[p+1];
        i8.b = pb[p+1];
      end else i8.start = 1'b0;
      tick;
      check($sformatf("b2b%0d_next", p), 32'({i8.busy, i8.done}), p < 2 ? 32'b10 : 32'b00);
    end
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] a8, b8, d8;
      logic [15:0] a16, b16;
      logic br8;
      bit got8;
      a8 = 8'($urandom);
      b8 = (n % 10 == 0) ? a8 : 8'($urandom);
      a16 = 16'($urandom);
      b16 = (n % 10 == 5) ? a16 : 16'($urandom);
      got8 = 0;
      d8 = '0;
      br8 = 1'b0;
      i8.start = 1'b1; i8.a = a8; i8.b = b8;
      i16.start = 1'b1; i16.a = a16; i16.b = b16;
      tick;
      i8.start = 1'b0;
      i16.start = 1'b0;
      for (int i = 1; i <= 16; i++) begin
        tick;
        if (i8.done && !got8) begin
          got8 = 1;
          d8 = i8.diff;
          br8 = i8.borrow;
        end
      end
      check("rnd8_done", 32'(got8), 32'd1);
      check("rnd8_diff", 32'(d8), ref_diff(int'(a8), int'(b8), 8));
      check("rnd8_borrow", 32'(br8), 32'(a8 < b8));
      check("rnd16_done", 32'(i16.done), 32'd1);
      check("rnd16_diff", 32'(i16.diff), ref_diff(int'(a16), int'(b16), 16));
      check("rnd16_borrow", 32'(i16.borrow), 32'(a16 < b16));
      tick;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
